usr_shift_sequencer: RTL and testbench

//  Command-driven controller for a WIDTH-bit universal shift register (hold/shift/shift/load via 2-bit select).
//  - Accepts LOAD / SHIFT_R / SHIFT_L commands over a valid/ready handshake.
//  - Drives the register's select, parallel and serial inputs; monitors its q.
//  - Emits the serial bit leaving the register on each shift, and a done pulse carrying the final contents.

---
 rtl/usr_seq_pkg.sv | 44 ++++
 rtl/shift_down_counter.sv | 33 +++
 rtl/usr_shift_sequencer.sv | 169 ++++++++++++++++
 tb/tb_usr_shift_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_seq_pkg.sv
// Shared encodings for the universal shift register sequencer: command ops,
// register select codes, fill modes, controller states and the fill-bit helper.
package usr_seq_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SHR   = 2'b01;
    localparam logic [1:0] OP_SHL   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic [1:0] FILL_ZERO   = 2'b00;
    localparam logic [1:0] FILL_ONE    = 2'b01;
    localparam logic [1:0] FILL_ROTATE = 2'b10;
    localparam logic [1:0] FILL_SERIN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_e;

    // Bit entering the register on a shift, chosen by the latched fill mode.
    // Rotate recirculates the bit that is leaving on the same edge.
    function automatic logic fill_bit(input logic [1:0] fill,
                                      input logic       leaving,
                                      input logic       serIn);
        logic b;
        b = 1'b0;
        case (fill)
            FILL_ZERO:   b = 1'b0;
            FILL_ONE:    b = 1'b1;
            FILL_ROTATE: b = leaving;
            FILL_SERIN:  b = serIn;
            default:     b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/shift_down_counter.sv
// Down-counter holding the number of shifts still to issue for the current
// command. Loaded on command accept, decremented once per issued shift.
module shift_down_counter
    import usr_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_zero,
    output logic             is_one
);

    logic [CNT_W-1:0] count_q;

    // Count register: clear on reset, load wins over decrement, never wraps below zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign is_zero = (count_q == '0);
    assign is_one  = (count_q == CNT_W'(1));

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven controller for a WIDTH-bit universal shift register.
// Accepts LOAD / SHIFT_R / SHIFT_L commands on a valid/ready handshake, drives
// the register's select and data inputs, reports each leaving serial bit, and
// pulses done with the final register contents.
// SHIFT_R moves bits toward the MSB (new bit enters q[0], q[WIDTH-1] leaves);
// SHIFT_L moves bits toward the LSB (new bit enters q[WIDTH-1], q[0] leaves).
module usr_shift_sequencer
    import usr_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [1:0]       cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
    input  logic             abort,
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_in,
    output logic             usr_serialright,
    output logic             usr_serialleft,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] result_data
);

    seq_state_e       state_q, state_d;
    logic             aborted_q, aborted_d;
    logic [1:0]       op_q;
    logic [1:0]       fill_q;
    logic [WIDTH-1:0] data_q;

    logic accept;
    logic cntDec;
    logic cntZero;
    logic cntOne;
    logic leavingBit;
    logic enteringBit;

    assign accept = (state_q == ST_IDLE) && cmd_valid;

    // Shifts remaining for the active command live in their own counter.
    shift_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .clr      (clr),
        .load     (accept),
        .load_val (cmd_count),
        .dec      (cntDec),
        .is_zero  (cntZero),
        .is_one   (cntOne)
    );

    // Which end of the register empties depends on direction; rotate feeds it back in.
    assign leavingBit  = (op_q == OP_SHR) ? usr_q[WIDTH-1] : usr_q[0];
    assign enteringBit = fill_bit(fill_q, leavingBit, ser_in);

    // State and abort flag registers; reset returns the controller to idle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aborted_q <= aborted_d;
        end
    end

    // Command fields are captured once at accept and held for the whole command.
    always_ff @(posedge clk) begin
        if (clr) begin
            op_q   <= OP_LOAD;
            fill_q <= FILL_ZERO;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            fill_q <= cmd_fill;
            data_q <= cmd_data;
        end
    end

    // Next-state and output decode; an abort in LOAD/SHIFT suppresses the register action.
    always_comb begin
        state_d         = state_q;
        aborted_d       = aborted_q;
        cmd_ready       = 1'b0;
        usr_select      = SEL_HOLD;
        usr_in          = '0;
        usr_serialright = 1'b0;
        usr_serialleft  = 1'b0;
        ser_out         = 1'b0;
        ser_out_valid   = 1'b0;
        done            = 1'b0;
        aborted         = 1'b0;
        result_data     = '0;
        cntDec          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    aborted_d = 1'b0;
                    if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (((cmd_op == OP_SHR) || (cmd_op == OP_SHL)) &&
                                 (cmd_count != '0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_LOAD: begin
                usr_in  = data_q;
                state_d = ST_DONE;
                if (abort) begin
                    aborted_d = 1'b1;
                end else begin
                    usr_select = SEL_LOAD;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (cntZero) begin
                    state_d = ST_DONE;
                end else begin
                    ser_out       = leavingBit;
                    ser_out_valid = 1'b1;
                    cntDec        = 1'b1;
                    if (op_q == OP_SHR) begin
                        usr_select      = SEL_SHR;
                        usr_serialright = enteringBit;
                    end else begin
                        usr_select     = SEL_SHL;
                        usr_serialleft = enteringBit;
                    end
                    if (cntOne) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done        = 1'b1;
                aborted     = aborted_q;
                result_data = usr_q;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench for usr_shift_sequencer. A behavioural universal shift
// register sits on the same clk/clr; expected outputs come from an arithmetic
// model of each command's cycle-by-cycle effect on the register contents.
// Output bundle bit order in messages: rdy sel[1:0] uin[3:0] sr sl so sov dn ab res[3:0].
module tb_usr_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic             rdy;
        logic [1:0]       sel;
        logic [WIDTH-1:0] uin;
        logic             sr;
        logic             sl;
        logic             so;
        logic             sov;
        logic             dn;
        logic             ab;
        logic [WIDTH-1:0] res;
    } outs_t;

    logic             clk = 1'b0;
    logic             clr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [1:0]       cmd_fill;
    logic [WIDTH-1:0] cmd_data;
    logic             ser_in;
    logic             abort;
    logic [WIDTH-1:0] regQ;
    logic [1:0]       usr_select;
    logic [WIDTH-1:0] usr_in;
    logic             usr_serialright;
    logic             usr_serialleft;
    logic             ser_out;
    logic             ser_out_valid;
    logic             done;
    logic             aborted;
    logic [WIDTH-1:0] result_data;

    int errors = 0;
    int checks = 0;
    int refQ   = 0;

    always #5 clk = ~clk;

    usr_shift_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .clr             (clr),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_count       (cmd_count),
        .cmd_fill        (cmd_fill),
        .cmd_data        (cmd_data),
        .ser_in          (ser_in),
        .abort           (abort),
        .usr_q           (regQ),
        .usr_select      (usr_select),
        .usr_in          (usr_in),
        .usr_serialright (usr_serialright),
        .usr_serialleft  (usr_serialleft),
        .ser_out         (ser_out),
        .ser_out_valid   (ser_out_valid),
        .done            (done),
        .aborted         (aborted),
        .result_data     (result_data)
    );

    // The universal shift register being controlled.
    always_ff @(posedge clk) begin
        if (clr) begin
            regQ <= '0;
        end else begin
            case (usr_select)
                2'b01:   regQ <= {regQ[WIDTH-2:0], usr_serialright};
                2'b10:   regQ <= {usr_serialleft, regQ[WIDTH-1:1]};
                2'b11:   regQ <= usr_in;
                default: regQ <= regQ;
            endcase
        end
    end

    function automatic outs_t observe();
        outs_t o;
        o.rdy = cmd_ready;
        o.sel = usr_select;
        o.uin = usr_in;
        o.sr  = usr_serialright;
        o.sl  = usr_serialleft;
        o.so  = ser_out;
        o.sov = ser_out_valid;
        o.dn  = done;
        o.ab  = aborted;
        o.res = result_data;
        return o;
    endfunction

    // Issue one command and check every cycle until its done pulse.
    // abortAt: cycle index (0 = accept cycle) at which abort is raised, -1 for none.
    task automatic runCommand(input string name, input logic [1:0] op, input int count,
                              input logic [1:0] fill, input logic [WIDTH-1:0] data,
                              input int abortAt, input bit holdValid);
        int    c;
        int    remaining;
        int    leaving;
        int    entering;
        bit    loadPending;
        bit    wasAborted;
        bit    finished;
        outs_t exp;
        outs_t got;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CNT_W'(count);
        cmd_fill  = fill;
        cmd_data  = data;
        abort     = (abortAt == 0);
        ser_in    = 1'($urandom_range(0, 1));
        #1;
        exp     = '0;
        exp.rdy = 1'b1;
        got     = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s accept: got %b want %b", name, got, exp);
        end

        loadPending = (op == 2'b00);
        remaining   = ((op == 2'b01) || (op == 2'b10)) ? count : 0;
        wasAborted  = 1'b0;
        finished    = 1'b0;
        c           = 1;
        while (!finished) begin
            @(negedge clk);
            if (holdValid) begin
                cmd_op    = 2'($urandom);
                cmd_count = CNT_W'($urandom);
                cmd_fill  = 2'($urandom);
                cmd_data  = WIDTH'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            abort  = (c == abortAt);
            ser_in = 1'($urandom_range(0, 1));
            #1;
            exp = '0;
            if (loadPending) begin
                exp.uin = data;
                if (abort) begin
                    wasAborted = 1'b1;
                end else begin
                    exp.sel = 2'b11;
                    refQ    = int'(data);
                end
                loadPending = 1'b0;
            end else if (remaining > 0) begin
                if (abort) begin
                    wasAborted = 1'b1;
                    remaining  = 0;
                end else begin
                    leaving = (op == 2'b01) ? ((refQ >> (WIDTH - 1)) & 1) : (refQ & 1);
                    case (fill)
                        2'b00:   entering = 0;
                        2'b01:   entering = 1;
                        2'b10:   entering = leaving;
                        default: entering = int'(ser_in);
                    endcase
                    exp.sel = op;
                    exp.so  = 1'(leaving);
                    exp.sov = 1'b1;
                    if (op == 2'b01) begin
                        exp.sr = 1'(entering);
                        refQ   = ((refQ * 2) + entering) % (1 << WIDTH);
                    end else begin
                        exp.sl = 1'(entering);
                        refQ   = (refQ / 2) + (entering << (WIDTH - 1));
                    end
                    remaining--;
                end
            end else begin
                exp.dn   = 1'b1;
                exp.ab   = wasAborted;
                exp.res  = WIDTH'(refQ);
                finished = 1'b1;
            end
            got = observe();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s cyc%0d: got %b want %b", name, c, got, exp);
            end
            c++;
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        outs_t exp;
        outs_t got;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        exp     = '0;
        exp.rdy = 1'b1;
        got     = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %b want %b", got, exp);
        end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        #1;
        got = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b want %b", got, exp);
        end
        refQ = 0;
    endtask

    task automatic test_load();
        runCommand("load_1011", 2'b00, 0, 2'b00, 4'b1011, -1, 1'b0);
    endtask

    task automatic test_shift_right_zero();
        runCommand("shr2_zero", 2'b01, 2, 2'b00, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_shift_left_rotate();
        runCommand("reload_1011", 2'b00, 0, 2'b00, 4'b1011, -1, 1'b0);
        runCommand("shl4_rot", 2'b10, 4, 2'b10, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_abort();
        runCommand("load_0000", 2'b00, 0, 2'b00, 4'b0000, -1, 1'b0);
        runCommand("shr7_one_abort", 2'b01, 7, 2'b01, 4'b0000, 3, 1'b0);
        runCommand("load_abort", 2'b00, 0, 2'b00, 4'b1111, 1, 1'b0);
        runCommand("abort_in_idle", 2'b10, 2, 2'b11, 4'b0000, 0, 1'b0);
        runCommand("abort_in_done", 2'b01, 1, 2'b01, 4'b0000, 2, 1'b0);
    endtask

    task automatic test_zero_count();
        runCommand("shr_count0", 2'b01, 0, 2'b01, 4'b0000, -1, 1'b0);
        runCommand("reserved_op", 2'b11, 9, 2'b01, 4'b0101, -1, 1'b0);
        runCommand("shl_max", 2'b10, 15, 2'b11, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        runCommand("busy_hold_shr", 2'b01, 5, 2'b10, 4'b0000, -1, 1'b1);
        runCommand("after_done_load", 2'b00, 0, 2'b00, 4'b0110, -1, 1'b1);
        runCommand("after_done_shl", 2'b10, 3, 2'b11, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_clr_mid_shift();
        outs_t exp;
        outs_t got;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_count = CNT_W'(7);
        cmd_fill  = 2'b01;
        abort     = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (usr_select !== 2'b01) begin
            errors++;
            $display("[TB] FAIL clr_pre_shift: select %b want 01", usr_select);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        exp     = '0;
        exp.rdy = 1'b1;
        got     = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL clr_to_idle: got %b want %b", got, exp);
        end
        refQ = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL clr_no_done: done %b want 0 at %0d", done, i);
            end
        end
        runCommand("post_clr_shr3", 2'b01, 3, 2'b01, 4'b0000, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0]       op;
        logic [1:0]       fill;
        logic [WIDTH-1:0] data;
        int               count;
        int               abortAt;
        for (int n = 0; n < 30; n++) begin
            op      = 2'($urandom);
            fill    = 2'($urandom);
            data    = WIDTH'($urandom);
            count   = $urandom_range(0, (1 << CNT_W) - 1);
            abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, count + 2)) : -1;
            runCommand($sformatf("rand%0d", n), op, count, fill, data, abortAt,
                       1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        clr       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_count = '0;
        cmd_fill  = '0;
        cmd_data  = '0;
        ser_in    = 1'b0;
        abort     = 1'b0;

        test_reset();
        test_load();
        test_shift_right_zero();
        test_shift_left_rotate();
        test_abort();
        test_zero_count();
        test_back_to_back();
        test_clr_mid_shift();
        test_random();

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
